alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Sequencing and writeback stage wrapped around the 8-bit ripple-carry ALU. It accepts one operation at a time over a valid/ready request port and drives the ALU operand, carry-in and add/sub-select inputs from registers. It holds those inputs for a programmable settle time, then captures the ALU sum and carry-out into an 8-bit accumulator and a flag register. Each result is returned over a valid/ready response port.

## Interface

**Parameters**
- `SETTLE_CYCLES`, default 1: number of cycles the ALU inputs are held stable before capture. Legal range 1..15.

**Ports**
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_op` input 3: opcode.
- `req_data` input 8: operand B / load value.
- `alu_a` output 8: to ALU `a1`.
- `alu_b` output 8: to ALU `b1`, raw operand; the ALU inverts it internally when `alu_sel`=1.
- `alu_cin` output 1: to ALU `ALU_cin1`.
- `alu_sel` output 1: to ALU `ALU_sel1`; 0=add, 1=subtract.
- `alu_res` input 8: from ALU `alu_out`.
- `alu_cout` input 1: from ALU `Cout`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output 8: result byte.
- `acc` output 8: current accumulator.
- `flag_c`, `flag_z`, `flag_n`, `flag_v` output 1 each: carry, zero, negative, overflow.

## Operation

**Opcodes.** A=`acc`, B=`req_data` latched at accept.
- 000 LDA: `acc`<=B. Z/N updated; C/V unchanged. No ALU pass.
- 001 ADD: sel=0, cin=0.
- 010 ADC: sel=0, cin=`flag_c`.
- 011 SUB: sel=1, cin=1.
- 100 SBC: sel=1, cin=`flag_c`.
- 101 CMP: as SUB. Flags updated; `acc` not written. `rsp_data` = difference.
- 110 INC: B forced to 0, sel=0, cin=1.
- 111 CLC: `flag_c`<=0, others unchanged. `rsp_data`=`acc`. No ALU pass.

**Carry convention.**
- C = `alu_cout` for all ALU ops.
- For SUB/SBC/CMP, C=1 means no borrow. SBC with C=0 computes A-B-1.

**Flags.**
- Z = (result==0).
- N = result[7].

**States.**
- IDLE: `req_ready`=1. On accept, go to EXEC (ALU ops) or RESP (LDA/CLC). Load `alu_a`, `alu_b`, `alu_cin`, `alu_sel` registers at the accepting edge.
- EXEC: down-counter loaded with SETTLE_CYCLES-1. On the last EXEC cycle, sample `alu_res`/`alu_cout` at the clock edge into `acc`/flags/`rsp_data`, then go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and flags are stable. On `rsp_valid && rsp_ready`, go to IDLE.

**Held outputs.**
- `alu_*` outputs are registered and hold their last value outside EXEC.
- The `flag_c` used by ADC/SBC is the value at the accepting edge.

## Timing

**Reset values.** State IDLE. `acc`, `rsp_data`, all flags, and all `alu_*` outputs are 0. `rsp_valid`=0.

**`req_ready`.** Equals (state==IDLE) && !rst, so it is 0 while reset is asserted.

**ALU ops.**
- Accept at cycle T.
- EXEC spans T+1..T+SETTLE_CYCLES.
- `rsp_valid` rises at T+SETTLE_CYCLES+1.

**LDA/CLC.** `rsp_valid` rises at T+1.

**Throughput.** With `rsp_ready` tied high, the minimum accept-to-accept interval is SETTLE_CYCLES+2 for ALU ops and 2 for LDA/CLC.

**Back-pressure.** `rsp_valid` stays high and `rsp_data`/flags stay frozen until `rsp_ready`. No new request is accepted meanwhile.

**Request-side rules.**
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until it is accepted.
- `req_op`/`req_data` are sampled only on the accepting edge.

**Reset mid-operation.** Asserting `rst` in EXEC or RESP discards the operation. All registers take their reset values immediately. No response is ever issued for the discarded operation.

**Wrap-around.** 0xFF+0x01 gives 0x00 with C=1, Z=1.

## Configuration

**`ALU_EXEC_OVERFLOW_EN` defined:**
- `flag_v` is computed on every ALU op, using A, B and r=`alu_res`:
  - Add/INC: (A[7]==B[7]) && (r[7]!=A[7]).
  - Sub/SBC/CMP: (A[7]!=B[7]) && (r[7]!=A[7]).
- LDA and CLC leave `flag_v` unchanged.

**Not defined:**
- `flag_v` is tied to 0.
- The V logic and its register are absent.
- All other behaviour is identical.

## Test plan

All scenarios use SETTLE_CYCLES=1 and a behavioural ripple-carry ALU model, except scenario 5.

1. Reset, then LDA 0x3C with `rsp_ready`=1 → `rsp_valid` at T+1, `acc`=0x3C, Z=0, N=0, C=0; `req_ready` high again at T+2.
2. LDA 0xFF, then ADD 0x01 → `rsp_valid` at T+2, `acc`=0x00, C=1, Z=1, N=0; `alu_a`=0xFF, `alu_b`=0x01, `alu_sel`=0, `alu_cin`=0 during EXEC.
3. LDA 0x10, then SUB 0x20 → `acc`=0xF0, C=0, N=1. Follow with SBC 0x00 → `acc`=0xEF, C=1.
4. LDA 0x7F, then ADD 0x01 → `acc`=0x80, N=1. With the macro V=1; without it V=0. Follow with CMP 0x80 → Z=1, `acc` stays 0x80.
5. SETTLE_CYCLES=4, `rsp_ready` held low for 6 cycles after `rsp_valid` → `rsp_valid` at T+5, data stable while stalled, `req_ready`=0 throughout. A second request held with `req_valid` is accepted only in the cycle after the `rsp_ready` handshake.
6. Assert `rst` during EXEC of ADD → `rsp_valid` never rises for that op, `acc`=0, flags=0, `alu_*`=0; `req_ready`=1 in the first cycle after `rst` deasserts.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencing and writeback stage around an external 8-bit
// ripple-carry ALU. Accepts one op over a valid/ready request port, holds the
// ALU inputs for SETTLE_CYCLES, captures sum/carry into acc and flags, and
// returns the result over a valid/ready response port.
// Build macro ALU_EXEC_OVERFLOW_EN: when defined, flag_v tracks signed
// overflow of ALU ops; when undefined, flag_v is tied to 0.
module alu_exec_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_cin,
   output logic       alu_sel,
   input  logic [7:0] alu_res,
   input  logic       alu_cout,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] acc,
   output logic       flag_c,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_v
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_LDA = 3'b000,
      OP_ADD = 3'b001,
      OP_ADC = 3'b010,
      OP_SUB = 3'b011,
      OP_SBC = 3'b100,
      OP_CMP = 3'b101,
      OP_INC = 3'b110,
      OP_CLC = 3'b111
   } op_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   op_t        r_op;
   op_t        w_req_op;
   logic [3:0] r_cnt;
   logic [7:0] r_alu_a;
   logic [7:0] r_alu_b;
   logic       r_alu_cin;
   logic       r_alu_sel;
   logic [7:0] r_acc;
   logic [7:0] r_rsp_data;
   logic       r_flag_c;
   logic       r_flag_z;
   logic       r_flag_n;

   logic       w_accept;
   logic       w_capture;
   logic       w_req_is_alu;
   logic       w_cin;
   logic       w_sel;
   logic [7:0] w_b;

   // Decode the incoming opcode into ALU control values
   always_comb begin
      w_req_op     = op_t'(req_op);
      w_req_is_alu = 1'b1;
      w_sel        = 1'b0;
      w_cin        = 1'b0;
      w_b          = req_data;
      case (w_req_op)
         OP_LDA, OP_CLC: w_req_is_alu = 1'b0;
         OP_ADD:         w_cin = 1'b0;
         OP_ADC:         w_cin = r_flag_c;
         OP_SUB, OP_CMP: begin
            w_sel = 1'b1;
            w_cin = 1'b1;
         end
         OP_SBC: begin
            w_sel = 1'b1;
            w_cin = r_flag_c;
         end
         OP_INC: begin
            w_b   = '0;
            w_cin = 1'b1;
         end
         default: w_req_is_alu = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_req_is_alu ? ST_EXEC : ST_RESP;
            end
         end
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: handshakes, accept strobe and capture strobe
   always_comb begin
      req_ready = (r_state == ST_IDLE) && !rst;
      rsp_valid = (r_state == ST_RESP);
      w_accept  = req_valid && req_ready;
      w_capture = (r_state == ST_EXEC) && (r_cnt == '0);
   end

   // Opcode latch and settle down-counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op  <= OP_LDA;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_op  <= w_req_op;
         r_cnt <= CNT_LOAD;
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // ALU input registers; only ALU ops reload them, so they hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_cin <= 1'b0;
         r_alu_sel <= 1'b0;
      end else if (w_accept && w_req_is_alu) begin
         r_alu_a   <= r_acc;
         r_alu_b   <= w_b;
         r_alu_cin <= w_cin;
         r_alu_sel <= w_sel;
      end
   end

   // Writeback: LDA/CLC complete at accept, ALU ops on the last settle cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc      <= '0;
         r_rsp_data <= '0;
         r_flag_c   <= 1'b0;
         r_flag_z   <= 1'b0;
         r_flag_n   <= 1'b0;
      end else if (w_accept) begin
         case (w_req_op)
            OP_LDA: begin
               r_acc      <= req_data;
               r_rsp_data <= req_data;
               r_flag_z   <= (req_data == '0);
               r_flag_n   <= req_data[7];
            end
            OP_CLC: begin
               r_flag_c   <= 1'b0;
               r_rsp_data <= r_acc;
            end
            default: r_flag_c <= r_flag_c;
         endcase
      end else if (w_capture) begin
         r_rsp_data <= alu_res;
         r_flag_c   <= alu_cout;
         r_flag_z   <= (alu_res == '0);
         r_flag_n   <= alu_res[7];
         if (r_op != OP_CMP) begin
            r_acc <= alu_res;
         end
      end
   end

`ifdef ALU_EXEC_OVERFLOW_EN
   logic r_flag_v;
   logic w_v;

   // Signed overflow of the op currently settling; B is the raw operand
   always_comb begin
      w_v = 1'b0;
      if (r_alu_sel) begin
         w_v = (r_alu_a[7] != r_alu_b[7]) && (alu_res[7] != r_alu_a[7]);
      end else begin
         w_v = (r_alu_a[7] == r_alu_b[7]) && (alu_res[7] != r_alu_a[7]);
      end
   end

   // Overflow flag register, written only on ALU capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flag_v <= 1'b0;
      end else if (w_capture) begin
         r_flag_v <= w_v;
      end
   end

   assign flag_v = r_flag_v;
`else
   assign flag_v = 1'b0;
`endif

   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_cin  = r_alu_cin;
   assign alu_sel  = r_alu_sel;
   assign rsp_data = r_rsp_data;
   assign acc      = r_acc;
   assign flag_c   = r_flag_c;
   assign flag_z   = r_flag_z;
   assign flag_n   = r_flag_n;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: two instances (SETTLE_CYCLES 1 and 4),
// each with a behavioural ripple-carry ALU, a driver that pushes expected
// responses and a monitor that checks them when the DUT presents them.
`timescale 1ns/1ps
module tb_alu_exec_ctrl;

   typedef struct {
      int         t;
      int         lat;
      bit         alu;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sel;
      logic [7:0] data;
      logic [7:0] acc;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL i%0d_%s actual=0x%0h required=0x%0h time=%0t", inst, name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input int inst, input string name);
      checks++;
      failures++;
      $display("FAIL i%0d_%s bound expired time=%0t", inst, name, $time);
   endtask

   // Reference model: plain arithmetic on A, B and the current carry
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] bv, input logic [7:0] av,
                                  input logic c, input logic z, input logic n, input logic v,
                                  input int unsigned s);
      exp_t e;
      int ia, ib, sa, sb, r, sr, k;
      ia = av; ib = bv; sa = $signed(av); sb = $signed(bv);
      k = c ? 1 : 0;
      r = 0; sr = 0;
      e.t = 0; e.alu = 1'b1; e.a = av; e.b = bv; e.cin = 1'b0; e.sel = 1'b0;
      e.data = 8'h00; e.acc = av; e.c = c; e.z = z; e.n = n; e.v = v;
      case (op)
         3'd1: begin r = ia + ib;         e.c = (r > 255); sr = sa + sb; end
         3'd2: begin r = ia + ib + k;     e.c = (r > 255); sr = sa + sb + k; e.cin = c; end
         3'd3, 3'd5: begin
            r = ia - ib; e.c = (ia >= ib); sr = sa - sb; e.sel = 1'b1; e.cin = 1'b1;
         end
         3'd4: begin
            r = ia - ib - (1 - k); e.c = (ia >= ib + (1 - k)); sr = sa - sb - (1 - k);
            e.sel = 1'b1; e.cin = c;
         end
         3'd6: begin r = ia + 1; e.c = (r > 255); sr = sa + 1; e.b = 8'h00; e.cin = 1'b1; end
         default: e.alu = 1'b0;
      endcase
      if (e.alu) begin
         e.data = 8'(r);
         e.z = (e.data == 8'h00);
         e.n = e.data[7];
         if (op != 3'd5) e.acc = e.data;
`ifdef ALU_EXEC_OVERFLOW_EN
         e.v = (sr > 127) || (sr < -128);
`else
         e.v = 1'b0;
`endif
      end else if (op == 3'd0) begin
         e.data = bv; e.acc = bv; e.z = (bv == 8'h00); e.n = bv[7];
      end else begin
         e.c = 1'b0; e.data = av;
      end
      e.lat = e.alu ? int'(s) + 1 : 1;
      return e;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned S = (g == 0) ? 1 : 4;

      logic       rst, req_valid, req_ready, rsp_valid, rsp_ready;
      logic       alu_cin, alu_sel, alu_cout, flag_c, flag_z, flag_n, flag_v;
      logic [2:0] req_op;
      logic [7:0] req_data, alu_a, alu_b, alu_res, rsp_data, acc;
      exp_t       q[$];
      logic [7:0] m_acc;
      logic       m_c, m_z, m_n, m_v;
      int         last_hs = -1;
      int         rr_mode = 0;
      int         vcnt = 0;
      int         p_ta = -1;
      int         p_lat = 0;
      bit         done = 1'b0;

      // Behavioural ripple-carry ALU: a + (sel ? ~b : b) + cin
      assign {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, (alu_sel ? ~alu_b : alu_b)} + {8'd0, alu_cin};

      alu_exec_ctrl #(.SETTLE_CYCLES(S)) u_dut (
         .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
         .req_op(req_op), .req_data(req_data), .alu_a(alu_a), .alu_b(alu_b),
         .alu_cin(alu_cin), .alu_sel(alu_sel), .alu_res(alu_res), .alu_cout(alu_cout),
         .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .acc(acc),
         .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
      );

      // Response consumer: 0 always ready, 1 random, 2 low for 6 cycles of rsp_valid
      initial begin
         rsp_ready = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            vcnt = rsp_valid ? vcnt + 1 : 0;
            case (rr_mode)
               1: rsp_ready = ($urandom_range(0, 3) != 0);
               2: rsp_ready = (vcnt > 6);
               default: rsp_ready = 1'b1;
            endcase
         end
      end

      // Monitor: compare whatever the DUT presents against the queue head
      initial begin
         exp_t e;
         bit   prev_valid;
         prev_valid = 1'b0;
         forever begin
            @(negedge clk);
            if (rsp_valid) begin
               if (q.size() == 0) begin
                  chk(g, "spurious_rsp", 32'(rsp_valid), 32'd0);
               end else begin
                  e = q[0];
                  if (!prev_valid) chk(g, "rsp_latency", 32'(cyc - e.t), 32'(e.lat));
                  chk(g, "rsp_data", 32'(rsp_data), 32'(e.data));
                  chk(g, "acc", 32'(acc), 32'(e.acc));
                  chk(g, "flags_czvn", 32'({flag_c, flag_z, flag_n, flag_v}), 32'({e.c, e.z, e.n, e.v}));
                  chk(g, "req_ready_in_resp", 32'(req_ready), 32'd0);
                  if (rsp_ready) begin
                     void'(q.pop_front());
                     last_hs = cyc;
                  end
               end
            end else if (q.size() > 0) begin
               e = q[0];
               if (e.alu && (cyc >= e.t + 1) && (cyc <= e.t + int'(S))) begin
                  chk(g, "alu_inputs", 32'({alu_a, alu_b, alu_cin, alu_sel}), 32'({e.a, e.b, e.cin, e.sel}));
               end
            end
            prev_valid = rsp_valid;
         end
      end

      task automatic send(input logic [2:0] op, input logic [7:0] d, output int ta);
         exp_t e;
         bit   rdy;
         int   tc;
         ta = -1;
         @(negedge clk);
         req_valid = 1'b1; req_op = op; req_data = d;
         for (int n = 0; n < 400 && ta < 0; n++) begin
            if (n > 0) @(negedge clk);
            rdy = req_ready;
            tc  = cyc;
            @(posedge clk);
            if (rdy) ta = tc;
         end
         #1;
         req_valid = 1'b0; req_op = 3'($urandom); req_data = 8'($urandom);
         if (ta < 0) begin
            timeout_fail(g, "accept");
         end else begin
            e = model(op, d, m_acc, m_c, m_z, m_n, m_v, S);
            e.t = ta;
            q.push_back(e);
            m_acc = e.acc; m_c = e.c; m_z = e.z; m_n = e.n; m_v = e.v;
            if (rr_mode == 0 && p_ta >= 0) chk(g, "accept_interval", 32'(ta - p_ta), 32'(p_lat + 1));
            p_ta = ta; p_lat = e.lat;
         end
      endtask

      task automatic drain();
         for (int n = 0; n < 400 && q.size() > 0; n++) @(negedge clk);
         if (q.size() > 0) timeout_fail(g, "drain");
         p_ta = -1;
      endtask

      task automatic check_reset_vals(input string tag);
         chk(g, {tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
         chk(g, {tag, "_req_ready"}, 32'(req_ready), 32'd0);
         chk(g, {tag, "_acc"}, 32'(acc), 32'd0);
         chk(g, {tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
         chk(g, {tag, "_flags"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
         chk(g, {tag, "_alu_out"}, 32'({alu_a, alu_b, alu_cin, alu_sel}), 32'd0);
      endtask

      // Called just after a negedge: pulse reset mid-cycle and check recovery
      task automatic reset_now(input string tag);
         #2 rst = 1'b1;
         q.delete();
         m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
         #1 check_reset_vals(tag);
         @(negedge clk);
         #2 rst = 1'b0;
         #1 chk(g, {tag, "_ready_after"}, 32'(req_ready), 32'd1);
         p_ta = -1;
      endtask

      // Driver: directed sequences, stall, resets, then random traffic
      initial begin
         int ta, ta2, op;
         logic [7:0] d;
         logic [7:0] corners [4];
         corners = '{8'h00, 8'hFF, 8'h7F, 8'h80};
         rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00;
         m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
         repeat (3) @(negedge clk);
         check_reset_vals("por");
         #2 rst = 1'b0;
         #1 chk(g, "ready_after_por", 32'(req_ready), 32'd1);

         send(3'd0, 8'h3C, ta); send(3'd0, 8'hFF, ta); send(3'd1, 8'h01, ta);
         send(3'd0, 8'h10, ta); send(3'd3, 8'h20, ta); send(3'd4, 8'h00, ta);
         send(3'd0, 8'h7F, ta); send(3'd1, 8'h01, ta); send(3'd5, 8'h80, ta);
         send(3'd6, 8'h55, ta); send(3'd2, 8'hFF, ta); send(3'd7, 8'hAA, ta);
         send(3'd2, 8'h01, ta); send(3'd0, 8'hFF, ta); send(3'd6, 8'h00, ta);
         send(3'd4, 8'h01, ta); send(3'd0, 8'h00, ta);
         drain();

         rr_mode = 2;
         send(3'd1, 8'h05, ta);
         send(3'd0, 8'h42, ta2);
         chk(g, "held_req_accept", 32'(ta2), 32'(last_hs + 1));
         drain();

         rr_mode = 0;
         send(3'd1, 8'h33, ta);
         @(negedge clk);
         reset_now("rst_exec");
         rr_mode = 2;
         send(3'd0, 8'h99, ta);
         @(negedge clk);
         reset_now("rst_resp");
         repeat (4) @(negedge clk);

         rr_mode = 1;
         p_ta = -1;
         repeat (150) begin
            op = $urandom_range(0, 7);
            d = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            send(3'(op), d, ta);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         drain();
         done = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(g_inst[0].done && g_inst[1].done) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      if (!(g_inst[0].done && g_inst[1].done)) begin
         checks++;
         failures++;
         $display("FAIL watchdog drivers did not complete within %0d cycles", n);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
